// File: rtl/match_index_extractor_pkg.sv
// Shared types and width helpers for the match-vector datapath
// (multiplier, index extractor and reporting logic).
package match_index_extractor_pkg;

    localparam int N_DEFAULT = 30;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic int calc_w(input int n);
        return 2 * n;
    endfunction

    function automatic int calc_idxw(input int w);
        return $clog2(w);
    endfunction

    // One extra code point so a fully set vector still fits.
    function automatic int calc_cntw(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/match_index_extractor_lsb_priority_encoder.sv
// Combinational lowest-set-bit finder over a W-bit vector.
// Reports the index of the lowest one and whether any bit is set.
module lsb_priority_encoder
    import match_index_extractor_pkg::*;
#(
    parameter  int W    = 60,
    localparam int IDXW = calc_idxw(W)
) (
    input  logic [W-1:0]    vec_in,
    output logic [IDXW-1:0] idx,
    output logic            any_set
);

    // Scanning downward lets the lowest set bit overwrite all higher ones.
    always_comb begin
        idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec_in[i]) begin
                idx = IDXW'(i);
            end
        end
    end

    assign any_set = |vec_in;

endmodule

// File: rtl/match_index_extractor.sv
// Streams out the bit positions of a captured match vector, lowest first,
// over a valid/ready handshake, then pulses done with the match count.
module match_index_extractor
    import match_index_extractor_pkg::*;
#(
    parameter  int N    = N_DEFAULT,
    localparam int W    = calc_w(N),
    localparam int IDXW = calc_idxw(W),
    localparam int CNTW = calc_cntw(W)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [W-1:0]    match_in,
    output logic            busy,
    output logic            idx_valid,
    output logic [IDXW-1:0] idx,
    input  logic            idx_ready,
    output logic            done,
    output logic [CNTW-1:0] match_count
);

    state_e          state_q, state_d;
    logic [W-1:0]    vec_q, vec_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            idx_valid_q, idx_valid_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic [IDXW-1:0] enc_idx;
    logic            enc_any;
    logic [W-1:0]    vec_cleared;

    lsb_priority_encoder #(
        .W (W)
    ) u_enc (
        .vec_in  (vec_q),
        .idx     (enc_idx),
        .any_set (enc_any)
    );

    assign vec_cleared = vec_q & ~(W'(1) << enc_idx);

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        idx_d       = idx_q;
        idx_valid_d = idx_valid_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    vec_d   = match_in;
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (enc_any) begin
                    idx_d       = enc_idx;
                    vec_d       = vec_cleared;
                    idx_valid_d = 1'b1;
                    state_d     = EMIT;
                end else begin
                    state_d = DONE;
                end
            end
            EMIT: begin
                if (idx_valid_q && idx_ready) begin
                    cnt_d = cnt_q + CNTW'(1);
                    // Remaining vector already excludes the index on the bus.
                    if (enc_any) begin
                        idx_d = enc_idx;
                        vec_d = vec_cleared;
                    end else begin
                        idx_valid_d = 1'b0;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            idx_q       <= '0;
            idx_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            idx_q       <= idx_d;
            idx_valid_q <= idx_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign idx_valid   = idx_valid_q;
    assign idx         = idx_q;
    assign match_count = cnt_q;

endmodule

// File: tb/tb_match_index_extractor.sv
// Randomised scoreboard bench for match_index_extractor.
// Stimulus pushes expected indices/counts; a negedge monitor checks them.
module tb_match_index_extractor;

    localparam int N    = 30;
    localparam int W    = 2 * N;
    localparam int IDXW = $clog2(W);
    localparam int CNTW = $clog2(W + 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [W-1:0]    match_in = '0;
    logic            busy;
    logic            idx_valid;
    logic [IDXW-1:0] idx;
    logic            idx_ready = 1'b0;
    logic            done;
    logic [CNTW-1:0] match_count;

    int errors = 0;
    int checks = 0;

    int exp_idx[$];
    int exp_cnt[$];

    int ready_mode = 0;

    match_index_extractor #(
        .N (N)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .match_in    (match_in),
        .busy        (busy),
        .idx_valid   (idx_valid),
        .idx         (idx),
        .idx_ready   (idx_ready),
        .done        (done),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: every set bit in ascending order, and their number.
    task automatic model_push(input logic [W-1:0] v);
        int k;
        k = 0;
        for (int i = 0; i < W; i++) begin
            if (v[i]) begin
                exp_idx.push_back(i);
                k++;
            end
        end
        exp_cnt.push_back(k);
    endtask

    function automatic int popcnt(input logic [W-1:0] v);
        int k;
        k = 0;
        for (int i = 0; i < W; i++) k += int'(v[i]);
        return k;
    endfunction

    // Ready driver: 0 low, 1 high, 2 random, 3 toggle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: idx_ready = 1'b0;
                1: idx_ready = 1'b1;
                2: idx_ready = 1'($urandom_range(0, 1));
                default: idx_ready = ~idx_ready;
            endcase
        end
    end

    // Monitor: compares handshakes and done pulses against the scoreboard.
    initial begin
        bit              prev_stall;
        logic [IDXW-1:0] prev_idx;
        int              e;
        prev_stall = 1'b0;
        prev_idx   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid_held", idx_valid, 1);
                    chk("stall_idx_held", idx, prev_idx);
                end
                prev_stall = idx_valid && !idx_ready;
                prev_idx   = idx;
                if (idx_valid && idx_ready) begin
                    if (exp_idx.size() == 0) begin
                        chk("unexpected_idx", idx, -1);
                    end else begin
                        e = exp_idx.pop_front();
                        chk("idx", idx, e);
                    end
                end
                if (done) begin
                    if (exp_cnt.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = exp_cnt.pop_front();
                        chk("match_count", match_count, e);
                    end
                    chk("idx_left_at_done", exp_idx.size(), 0);
                    chk("valid_at_done", idx_valid, 0);
                end
            end
        end
    end

    // One full operation; stall_n>0 with mode 0 stalls then toggles ready.
    task automatic run_op(input logic [W-1:0] v, input int mode,
                          input int stall_n, input bit inject);
        int k;
        int cyc;
        int first_v;
        @(posedge clk);
        #2;
        ready_mode = mode;
        start      = 1'b1;
        match_in   = v;
        model_push(v);
        k = popcnt(v);
        @(posedge clk);
        #2;
        start    = 1'b0;
        match_in = {$urandom, $urandom};
        cyc      = 1;
        first_v  = -1;
        chk("busy_after_start", busy, 1);
        chk("no_valid_cycle1", idx_valid, 0);
        while (!done && cyc < 2000) begin
            if (inject && cyc == 3) begin
                start    = 1'b1;
                match_in = ~v;
            end else begin
                start = 1'b0;
            end
            if (mode == 0 && cyc == 2 + stall_n) ready_mode = 3;
            @(posedge clk);
            #2;
            cyc++;
            if (idx_valid && first_v < 0) first_v = cyc;
        end
        start = 1'b0;
        if (!done) begin
            chk("done_timeout", cyc, -1);
        end else begin
            chk("busy_at_done", busy, 1);
            if (k > 0) chk("first_valid_latency", first_v, 2);
            if (mode == 1) chk("done_latency", cyc, (k == 0) ? 2 : k + 2);
        end
        @(posedge clk);
        #2;
        chk("idle_not_busy", busy, 0);
        chk("idle_no_done", done, 0);
        ready_mode = 0;
    endtask

    initial begin
        logic [W-1:0] v;
        int           guard;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_valid", idx_valid, 0);
        chk("rst_idx", idx, 0);
        chk("rst_done", done, 0);
        chk("rst_count", match_count, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        run_op('0, 1, 0, 1'b0);
        v = '0;
        v[0] = 1'b1;
        v[W-1] = 1'b1;
        run_op(v, 1, 0, 1'b0);
        run_op('1, 1, 0, 1'b0);
        run_op(W'(64'h0A), 0, 5, 1'b0);
        run_op(W'(64'h8000_0001_0020_0104), 0, 6, 1'b1);

        for (int t = 0; t < 12; t++) begin
            v = {$urandom, $urandom};
            if (t % 3 == 0) v = v & {$urandom, $urandom} & {$urandom, $urandom};
            run_op(v, 1 + (t % 2), 0, 1'b0);
        end

        // Abandon an operation with ten indices still pending.
        v = W'(64'h0FFF) << 10;
        v[W-1] = 1'b1;
        @(posedge clk);
        #2;
        ready_mode = 1;
        start      = 1'b1;
        match_in   = v;
        model_push(v);
        @(posedge clk);
        #2;
        start = 1'b0;
        guard = 0;
        while (!idx_valid && guard < 10) begin
            @(posedge clk);
            #2;
            guard++;
        end
        chk("pre_reset_valid", idx_valid, 1);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", idx_valid, 0);
        chk("mid_rst_idx", idx, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_count", match_count, 0);
        exp_idx.delete();
        exp_cnt.delete();
        ready_mode = 0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        run_op(W'(64'h30), 1, 0, 1'b0);
        run_op(W'(64'h5) << 40, 2, 0, 1'b0);

        repeat (3) @(posedge clk);
        chk("scoreboard_idx_empty", exp_idx.size(), 0);
        chk("scoreboard_cnt_empty", exp_cnt.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
